// File: rtl/udp_packer_pkg.sv
// Shared types and widths for the UDP TX packetizer.
package udp_packer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;

   localparam int CNT_W  = 10;
   localparam int IDLE_W = 16;
   localparam int HDR_W  = 32;

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXIS register slice. A load strobe writes a new beat; the beat
// is held stable until the downstream handshake, then the slot empties.
module axis_out_reg #(
   parameter int W = 32
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_last,
   input  logic         m_tready,
   output logic         m_tvalid,
   output logic [W-1:0] m_tdata,
   output logic         m_tlast
);

   // Output slot: load has priority; otherwise drain on handshake.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tlast  <= 1'b0;
      end else if (load) begin
         m_tvalid <= 1'b1;
         m_tdata  <= load_data;
         m_tlast  <= load_last;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
      end
   end

endmodule

// File: rtl/udp_tx_packer.sv
// Packs an unframed 32-bit sample stream into UDP payload packets:
// one sequence-number header word followed by up to MAX_WORDS data words.
// A packet closes when full, after IDLE_TIMEOUT idle cycles, or on flush.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no open packet; first accepted word emits the header
//   DATA  | packet open; newest word waits in hold until the next word or close
module udp_tx_packer
   import udp_packer_pkg::*;
#(
   parameter int          MAX_WORDS    = 367,
   parameter int          IDLE_TIMEOUT = 1024,
   parameter logic [31:0] SEQ_INIT     = 32'h0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        flush,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic [31:0] seq_num,
   output logic        pkt_done
);

   state_t             state;
   logic               hold_v;
   logic [31:0]        hold_d;
   logic [CNT_W-1:0]   cnt;
   logic [IDLE_W-1:0]  idle_cnt;
   logic               flush_pend;
   logic               run_en;

   logic               out_free;
   logic               timeout_hit;
   logic               close;
   logic               close_now;
   logic               accept;
   logic               in_ready;
   logic               load;
   logic [HDR_W-1:0]   load_data;
   logic               load_last;

   assign out_free    = !m_axis_tvalid || m_axis_tready;
   assign timeout_hit = (IDLE_TIMEOUT != 0) && (idle_cnt >= IDLE_W'(IDLE_TIMEOUT));
   // A flush in the current cycle already counts so that a word presented
   // alongside it is refused and starts the next packet.
   assign close       = (cnt == CNT_W'(MAX_WORDS)) || flush_pend || flush || timeout_hit;
   assign close_now   = (state == DATA) && hold_v && out_free && close;
   assign accept      = s_axis_tvalid && in_ready;
   assign s_axis_tready = in_ready;
   assign pkt_done    = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   // Input ready and output-slot load selection (close wins over new input).
   always_comb begin
      in_ready  = 1'b0;
      load      = 1'b0;
      load_data = '0;
      load_last = 1'b0;
      if (run_en) begin
         case (state)
            IDLE: begin
               in_ready = out_free;
               if (s_axis_tvalid && out_free) begin
                  load      = 1'b1;
                  load_data = seq_num;
               end
            end
            DATA: begin
               in_ready = !hold_v || (out_free && !close);
               if (close_now) begin
                  load      = 1'b1;
                  load_data = hold_d;
                  load_last = 1'b1;
               end else if (hold_v && out_free && s_axis_tvalid) begin
                  load      = 1'b1;
                  load_data = hold_d;
               end
            end
            default: ;
         endcase
      end
   end

   // Packet FSM: hold word, word count, idle timer, pending flush, sequence number.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         hold_v     <= 1'b0;
         hold_d     <= '0;
         cnt        <= '0;
         idle_cnt   <= '0;
         flush_pend <= 1'b0;
         seq_num    <= SEQ_INIT;
         run_en     <= 1'b0;
      end else begin
         run_en <= 1'b1;
         case (state)
            IDLE: begin
               idle_cnt <= '0;
               if (accept) begin
                  hold_v <= 1'b1;
                  hold_d <= s_axis_tdata;
                  cnt    <= CNT_W'(1);
                  state  <= DATA;
               end
            end
            DATA: begin
               if (close_now) begin
                  hold_v     <= 1'b0;
                  flush_pend <= 1'b0;
                  seq_num    <= seq_num + 32'd1;
                  cnt        <= '0;
                  idle_cnt   <= '0;
                  state      <= IDLE;
               end else begin
                  if (flush)
                     flush_pend <= 1'b1;
                  if (accept) begin
                     hold_v   <= 1'b1;
                     hold_d   <= s_axis_tdata;
                     cnt      <= cnt + CNT_W'(1);
                     idle_cnt <= '0;
                  end else if (hold_v && (idle_cnt != {IDLE_W{1'b1}})) begin
                     idle_cnt <= idle_cnt + IDLE_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   axis_out_reg #(
      .W (HDR_W)
   ) u_out (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .m_tready  (m_axis_tready),
      .m_tvalid  (m_axis_tvalid),
      .m_tdata   (m_axis_tdata),
      .m_tlast   (m_axis_tlast)
   );

endmodule
